booth_mul16: RTL
================

# booth_mul16

Iterative 16x16 signed multiplier for the EX stage, alongside `adder16`. It takes the same rs/rt operands the adder receives from the EX operand muxes. It produces a 32-bit product plus a 16-bit saturated result that feeds the ALU result mux next to `adder16.sum`. It uses radix-2 Booth recoding, one bit per cycle, and asserts `busy` so the hazard unit holds the pipeline while it runs.

## Interface
Parameters:
- `ITER`, 16, number of Booth iterations. It equals the operand width. Only 16 is supported.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply. Sampled only in IDLE or DONE.
- `a`  in  16  multiplicand (two's complement). Captured on accepted start.
- `b`  in  16  multiplier (two's complement). Captured on accepted start.
- `busy`  out  1  high while state is RUN.
- `done`  out  1  single-cycle pulse. High while state is DONE.
- `product`  out  32  full signed product a*b.
- `sat`  out  16  product saturated to signed 16 bits.
- `ovfl`  out  1  high when `product[31:15]` is not all-equal, i.e. the product does not fit in 16 signed bits.

## Operation
- Registers:
  - M: 16-bit multiplicand.
  - A: 17-bit accumulator, so add/sub never loses the sign.
  - Q: 16-bit multiplier/low product.
  - q_1: 1-bit Booth lookbehind.
  - cnt: 4-bit iteration counter.
  - Result registers for `product`, `sat` and `ovfl`.
- States: IDLE, RUN, DONE.
  - IDLE: if `start`, load M=a, Q=b, A=0, q_1=0, cnt=0, then go to RUN. Otherwise stay.
  - RUN: perform one iteration per cycle, then cnt++. When cnt==15 at the edge, write the result registers and go to DONE.
  - DONE: if `start`, accept a new operation (same load as IDLE) and go to RUN. Otherwise go to IDLE.
- Booth iteration on {Q[0], q_1}:
  - 01: A = A + sext17(M).
  - 10: A = A - sext17(M).
  - 00 and 11: A unchanged.
  - Then arithmetic right shift of {A, Q, q_1} by 1, with A[16] replicated.
- Arithmetic width rules:
  - The 17-bit add/sub wraps, with no saturation inside the loop.
  - The product is {A[15:0], Q} after 16 iterations, and it is exact for all inputs, including 0x8000*0x8000.
- Saturation (same convention as the ALU):
  - `ovfl`=1 and `product[31]`=0 gives `sat`=0x7FFF.
  - `ovfl`=1 and `product[31]`=1 gives `sat`=0x8000.
  - Otherwise `sat`=`product[15:0]`.
- Result hold: `product`, `sat` and `ovfl` change only at the RUN→DONE edge. They hold through IDLE and through a subsequent RUN until the next completion.
- `start` in RUN is ignored. There is no queueing and no abort.
- `a` and `b` are don't-care except on the accepting edge.

## Timing
- Reset (synchronous, highest priority, in any state, including mid-RUN):
  - State becomes IDLE.
  - `busy`=0, `done`=0, `product`=0, `sat`=0, `ovfl`=0.
  - All internal registers are cleared.
- Start accepted at edge k:
  - `busy`=1 during cycles k+1 … k+16.
  - `done`=1 during cycle k+17 only.
  - Results are valid from cycle k+17.
- Latency: 17 cycles from the accepting edge to `done`. Throughput is one multiply per 17 cycles when back-to-back.
- Back-to-back: a `start` during DONE is accepted. `busy` rises in the cycle after DONE with no IDLE gap.
- Outputs are registered, with no combinational path from `start`, `a` or `b` to any output.
- `busy` is a pure state decode, with no dependence on `start`. The hazard unit stalls the instruction after the multiply on its own decode and releases on `done`.

## Test plan
- Reset: assert `rst` for 2 cycles → `busy`=0, `done`=0, `product`=0x00000000, `sat`=0x0000, `ovfl`=0. Also assert `rst` at RUN cycle 8 → same values next cycle, and `done` never pulses.
- 3*5: start with a=0x0003, b=0x0005 → `busy` high for exactly 16 cycles, then `done` at k+17, `product`=0x0000000F, `sat`=0x000F, `ovfl`=0.
- -7*6: a=0xFFF9, b=0x0006 → `product`=0xFFFFFFD6, `sat`=0xFFD6, `ovfl`=0.
- Extremes:
  - 0x8000*0x8000 → `product`=0x40000000, `ovfl`=1, `sat`=0x7FFF.
  - 0x7FFF*0x7FFF → 0x3FFF0001, `sat`=0x7FFF.
  - 0x0100*0xFF00 → 0xFFFF0000, `ovfl`=1, `sat`=0x8000.
  - 0x8000*0x0001 → 0xFFFF8000, `ovfl`=0, `sat`=0x8000.
- Handshake:
  - `start` held high through RUN with changing a/b → result matches only the operands captured at the first edge.
  - `start` in DONE with a=2, b=0xFFFD → next `done` exactly 17 cycles later, `product`=0xFFFFFFFA.
  - The previous result holds until then.
- Random: 10k random a/b pairs with random start gaps → `product` equals the signed 32-bit reference, and `sat`/`ovfl` equal the saturation rule, checked at every `done`.

Source files
------------

// File: rtl/booth_mul16.sv
// Iterative 16x16 signed radix-2 Booth multiplier: one recoded bit per cycle,
// registered 32-bit product plus a 16-bit saturated result and overflow flag.
module booth_mul16 #(
    parameter int ITER = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] sat,
    output logic        ovfl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load;
    logic        w_last;

    logic [15:0] r_m;
    logic [16:0] r_acc;
    logic [15:0] r_q;
    logic        r_q_1;
    logic [3:0]  r_cnt;

    logic [31:0] r_product;
    logic [15:0] r_sat;
    logic        r_ovfl;

    logic [16:0] w_m_ext;
    logic [16:0] w_acc_op;
    logic [16:0] w_acc_shift;
    logic [15:0] w_q_shift;
    logic [31:0] w_prod;
    logic        w_ovfl;
    logic [15:0] w_sat;

    // Next-state / control decode
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'(ITER - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One Booth step: 17-bit add/sub wraps; then arithmetic shift of {A,Q,q_1}
    always_comb begin
        w_m_ext = {r_m[15], r_m};
        case ({r_q[0], r_q_1})
            2'b01:   w_acc_op = r_acc + w_m_ext;
            2'b10:   w_acc_op = r_acc - w_m_ext;
            default: w_acc_op = r_acc;
        endcase
        w_acc_shift = {w_acc_op[16], w_acc_op[16:1]};
        w_q_shift   = {w_acc_op[0], r_q[15:1]};
        w_prod      = {w_acc_shift[15:0], w_q_shift};
        w_ovfl      = !((&w_prod[31:15]) || !(|w_prod[31:15]));
        if (w_ovfl) begin
            w_sat = w_prod[31] ? 16'h8000 : 16'h7FFF;
        end else begin
            w_sat = w_prod[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q_1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
            r_sat     <= '0;
            r_ovfl    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_m   <= a;
                r_q   <= b;
                r_acc <= '0;
                r_q_1 <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_shift;
                r_q   <= w_q_shift;
                r_q_1 <= r_q[0];
                r_cnt <= r_cnt + 4'd1;
            end
            // Results only move on the final iteration; they hold otherwise
            if (w_last) begin
                r_product <= w_prod;
                r_sat     <= w_sat;
                r_ovfl    <= w_ovfl;
            end
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;
    assign sat     = r_sat;
    assign ovfl    = r_ovfl;

endmodule
